// File: rtl/lab2_proc_int_mul_seq_pkg.sv
// Shared types for the iterative multiply sequencer.
//   state_e : control FSM states
//   sel_e   : datapath register input select (hold / load operands / one shift-add step)
package lab2_proc_int_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2
    } sel_e;

endpackage

// File: rtl/lab2_proc_int_mul_seq_dpath.sv
// Shift-add datapath: multiplicand/multiplier shift registers, accumulator and step counter.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   sel              register input select from the control FSM
//   a_in, b_in       operands captured on LOAD
//   result           accumulated low NBITS product bits
//   b_lsb            current multiplier LSB
//   b_rest_zero      multiplier bits above the LSB are all zero (last useful step)
//   count_last       this step is the NBITS-th one
module lab2_proc_int_mul_seq_dpath
    import lab2_proc_int_mul_seq_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  sel_e             sel,
    input  logic [NBITS-1:0] a_in,
    input  logic [NBITS-1:0] b_in,
    output logic [NBITS-1:0] result,
    output logic             b_lsb,
    output logic             b_rest_zero,
    output logic             count_last
);

    localparam int CW = $clog2(NBITS) + 1;

    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        count_d  = count_q;
        case (sel)
            LOAD: begin
                a_d      = a_in;
                b_d      = b_in;
                result_d = '0;
                count_d  = '0;
            end
            STEP: begin
                // Carry out of the add is intentionally dropped: only low NBITS are kept.
                if (b_q[0]) result_d = result_q + a_q;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                count_d = count_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign result      = result_q;
    assign b_lsb       = b_q[0];
    assign b_rest_zero = (b_q[NBITS-1:1] == '0);
    assign count_last  = (count_q == CW'(NBITS - 1));

endmodule

// File: rtl/lab2_proc_int_mul_seq.sv
// Iterative shift-add multiplier for the X stage (MUL), val/rdy in and out.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   squash                     abandon any in-flight op, return to IDLE
//   istream_val/rdy/msg        operands {a, b}
//   ostream_val/rdy/msg        low NBITS of a*b
//
//   state | meaning
//   IDLE  | waiting for operands, istream_rdy high
//   CALC  | one shift-add step per cycle
//   DONE  | result presented until consumed
module lab2_proc_int_mul_seq
    import lab2_proc_int_mul_seq_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               squash,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*NBITS-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [NBITS-1:0]   ostream_msg
);

    state_e state_q, state_d;
    sel_e   sel;
    logic   b_lsb, b_rest_zero, count_last;
    logic   exit_calc;

    lab2_proc_int_mul_seq_dpath #(.NBITS(NBITS)) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .a_in        (istream_msg[2*NBITS-1:NBITS]),
        .b_in        (istream_msg[NBITS-1:0]),
        .result      (ostream_msg),
        .b_lsb       (b_lsb),
        .b_rest_zero (b_rest_zero),
        .count_last  (count_last)
    );

    assign istream_rdy = (state_q == IDLE) && !reset;
    assign ostream_val = (state_q == DONE) && !squash && !reset;

    // b_lsb only steers the adder inside the datapath; the FSM needs just the exit terms.
    assign exit_calc = count_last || ((EARLY_EXIT != 0) && b_rest_zero);

    always_comb begin
        state_d = state_q;
        sel     = HOLD;
        case (state_q)
            IDLE: begin
                // squash outranks the input handshake
                if (istream_val && istream_rdy && !squash) begin
                    sel     = LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                sel = STEP;
                if (exit_calc) state_d = DONE;
            end
            DONE: begin
                if (ostream_val && ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (squash) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    logic unused_ok;
    assign unused_ok = b_lsb;

endmodule

// File: tb/tb_lab2_proc_int_mul_seq.sv
module tb_lab2_proc_int_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        squash;
    logic        istream_val;
    logic        istream_rdy;
    logic [63:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;

    // second instance with early exit disabled
    logic        n_istream_val;
    logic        n_istream_rdy;
    logic [63:0] n_istream_msg;
    logic        n_ostream_val;
    logic        n_ostream_rdy;
    logic [31:0] n_ostream_msg;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    lab2_proc_int_mul_seq #(.NBITS(32), .EARLY_EXIT(1)) dut (
        .clk(clk), .reset(reset), .squash(squash),
        .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_msg(istream_msg),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg)
    );

    lab2_proc_int_mul_seq #(.NBITS(32), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .reset(reset), .squash(squash),
        .istream_val(n_istream_val), .istream_rdy(n_istream_rdy), .istream_msg(n_istream_msg),
        .ostream_val(n_ostream_val), .ostream_rdy(n_ostream_rdy), .ostream_msg(n_ostream_msg)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_exp(output logic [31:0] e);
        if (sb.size() == 0) begin
            e = 'x;
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Entered and left on a negedge with the unit in IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int k, input int hold);
        int n;
        logic [31:0] e;
        chk("accept_rdy", 32'(istream_rdy), 32'd1);
        istream_msg = {a, b};
        istream_val = 1'b1;
        sb.push_back(a * b);
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        n = 1;
        while (!ostream_val && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(k + 1));
        if (!ostream_val) begin
            pop_exp(e);
            return;
        end
        if (hold > 0) begin
            istream_msg = {32'd11, 32'd13};
            istream_val = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_val", 32'(ostream_val), 32'd1);
            chk("hold_msg", ostream_msg, sb[0]);
            chk("hold_irdy", 32'(istream_rdy), 32'd0);
            @(negedge clk);
        end
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        pop_exp(e);
        #1;
        chk("xfer_val", 32'(ostream_val), 32'd1);
        chk("xfer_msg", ostream_msg, e);
        @(negedge clk);
        ostream_rdy = 1'b0;
        chk("idle_after", {30'd0, ostream_val, istream_rdy}, 32'd1);
    endtask

    task automatic run_ne(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int n;
        chk("ne_accept_rdy", 32'(n_istream_rdy), 32'd1);
        n_istream_msg = {a, b};
        n_istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_istream_val = 1'b0;
        n = 1;
        while (!n_ostream_val && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("ne_latency", 32'(n), 32'd33);
        n_ostream_rdy = 1'b1;
        #1;
        chk("ne_msg", n_ostream_msg, e);
        @(negedge clk);
        n_ostream_rdy = 1'b0;
        chk("ne_idle_after", {30'd0, n_ostream_val, n_istream_rdy}, 32'd1);
    endtask

    initial begin
        logic [31:0] e;
        int n;

        vecs[0] = '{32'd3,          32'd5,          3,  32'd15};
        vecs[1] = '{32'd7,          32'd0,          1,  32'd0};
        vecs[2] = '{32'hFFFF_FFFC,  32'd6,          3,  32'hFFFF_FFE8};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32, 32'h0000_0001};
        vecs[4] = '{32'd1,          32'd1,          1,  32'd1};
        vecs[5] = '{32'h1234_5678,  32'h8000_0000,  32, 32'h0000_0000};
        vecs[6] = '{32'hDEAD_BEEF,  32'h0000_0010,  5,  32'hEADB_EEF0};
        vecs[7] = '{32'd100,        32'd100,        7,  32'd10000};

        reset = 1'b1; squash = 1'b0;
        istream_val = 1'b0; istream_msg = '0; ostream_rdy = 1'b0;
        n_istream_val = 1'b0; n_istream_msg = '0; n_ostream_rdy = 1'b0;

        // reset held two cycles
        @(negedge clk);
        chk("rst_irdy", 32'(istream_rdy), 32'd0);
        chk("rst_oval", 32'(ostream_val), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_irdy", 32'(istream_rdy), 32'd1);
        chk("post_rst_oval", 32'(ostream_val), 32'd0);
        chk("post_rst_msg", ostream_msg, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].k, 0);

        // stall in DONE for five cycles
        run_op(32'd6, 32'd7, 3, 5);

        // squash in C2 of 9*9
        istream_msg = {32'd9, 32'd9};
        istream_val = 1'b1;
        sb.push_back(32'd81);
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        @(negedge clk);
        squash = 1'b1;
        @(negedge clk);
        squash = 1'b0;
        void'(sb.pop_front());
        #1;
        chk("sq_calc_irdy", 32'(istream_rdy), 32'd1);
        ostream_rdy = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (ostream_val) n++;
            @(negedge clk);
        end
        ostream_rdy = 1'b0;
        chk("sq_calc_no_xfer", 32'(n), 32'd0);
        run_op(32'd2, 32'd3, 2, 0);

        // squash in DONE together with ostream_rdy
        istream_msg = {32'd5, 32'd1};
        istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        @(negedge clk);
        chk("sq_done_val_before", 32'(ostream_val), 32'd1);
        squash = 1'b1;
        ostream_rdy = 1'b1;
        #1;
        chk("sq_done_val", 32'(ostream_val), 32'd0);
        @(negedge clk);
        squash = 1'b0;
        ostream_rdy = 1'b0;
        #1;
        chk("sq_done_idle", {30'd0, ostream_val, istream_rdy}, 32'd1);

        // squash in IDLE outranks istream_val
        @(negedge clk);
        squash = 1'b1;
        istream_msg = {32'd4, 32'd1};
        istream_val = 1'b1;
        @(negedge clk);
        squash = 1'b0;
        istream_val = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (ostream_val || !istream_rdy) n++;
            @(negedge clk);
        end
        chk("sq_idle_not_accepted", 32'(n), 32'd0);

        // reset mid-CALC
        istream_msg = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        istream_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_irdy", 32'(istream_rdy), 32'd0);
        chk("rst_mid_oval", 32'(ostream_val), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_after_irdy", 32'(istream_rdy), 32'd1);
        chk("rst_mid_after_msg", ostream_msg, 32'd0);
        @(negedge clk);
        run_op(32'd10, 32'd12, 4, 0);

        // early exit disabled: always 32 CALC cycles
        run_ne(32'd3, 32'd5, 32'd15);
        run_ne(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
